// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage: funct3 access codes, FSM encodings, byte-strobe masks.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  // funct3[1:0] encodes log2 of the access size in bytes
  function automatic logic [7:0] strb_base(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = STRB_B;
      2'd1:    m = STRB_H;
      2'd2:    m = STRB_W;
      default: m = STRB_D;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic m;
    case (size)
      2'd0:    m = 1'b0;
      2'd1:    m = off[0];
      2'd2:    m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed bytes from a raw doubleword and sign/zero-extends them to 64 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr,
  input  logic [2:0]  funct3,
  output logic [63:0] data_out
);

  logic [63:0] w_shifted;

  assign w_shifted = rdata >> {addr, 3'b000};

  always_comb begin
    data_out = '0;
    case (funct3)
      F3_LB:   data_out = {{56{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   data_out = {{48{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   data_out = {{32{w_shifted[31]}}, w_shifted[31:0]};
      F3_LD:   data_out = w_shifted;
      F3_LBU:  data_out = {56'd0, w_shifted[7:0]};
      F3_LHU:  data_out = {48'd0, w_shifted[15:0]};
      F3_LWU:  data_out = {32'd0, w_shifted[31:0]};
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues handshaked data-memory accesses, stalls while outstanding,
// and passes non-memory instructions straight through to MEM/WB.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] result_alu_in,
  input  logic [63:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] read_data_out,
  output logic [63:0] result_alu_out,
  output logic [4:0]  rd_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic        stall,
  output logic        mem_fault
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [63:0] r_load_buf;
  logic [63:0] r_alu;
  logic [4:0]  r_rd;
  logic [2:0]  r_f3;
  logic [2:0]  r_off;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic        r_is_load;
  logic        r_killed;

  logic        w_mem_op;
  logic        w_is_store;
  logic        w_fault_in;
  logic        w_timeout;
  logic [63:0] w_aligned;

  assign w_mem_op   = memread_in | memwrite_in;
  assign w_is_store = memwrite_in & ~memread_in;
  assign w_fault_in = w_mem_op & ((funct3_in == F3_ILL) | (w_is_store & funct3_in[2]) |
                                  misaligned(funct3_in[1:0], result_alu_in[2:0]));
  assign w_timeout  = (r_state == ST_WAIT) & ~dmem_ack & (r_cnt == TMO_LAST);

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .addr     (r_off),
    .funct3   (r_f3),
    .data_out (w_aligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_load_buf <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      r_alu      <= '0;
      r_rd       <= '0;
      r_f3       <= '0;
      r_off      <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_is_load  <= 1'b0;
      r_killed   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op && !w_fault_in) begin
            dmem_req   <= 1'b1;
            dmem_we    <= w_is_store;
            dmem_addr  <= {result_alu_in[63:3], 3'b000};
            dmem_wdata <= write_data_in << {result_alu_in[2:0], 3'b000};
            dmem_wstrb <= strb_base(funct3_in[1:0]) << result_alu_in[2:0];
            r_alu      <= result_alu_in;
            r_rd       <= rd_in;
            r_f3       <= funct3_in;
            r_off      <= result_alu_in[2:0];
            r_regwrite <= regwrite_in;
            r_memtoreg <= memtoreg_in;
            r_is_load  <= memread_in;
            r_killed   <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (r_is_load) r_load_buf <= w_aligned;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            dmem_req <= 1'b0;
            r_killed <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall          = 1'b0;
    mem_fault      = 1'b0;
    read_data_out  = '0;
    result_alu_out = result_alu_in;
    rd_out         = rd_in;
    memtoreg_out   = memtoreg_in;
    regwrite_out   = regwrite_in;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          regwrite_out = 1'b0;
          memtoreg_out = 1'b0;
          if (w_fault_in) mem_fault = 1'b1;
          else            stall     = 1'b1;
        end
      end
      ST_WAIT: begin
        stall          = 1'b1;
        mem_fault      = w_timeout;
        regwrite_out   = 1'b0;
        memtoreg_out   = 1'b0;
        result_alu_out = r_alu;
        rd_out         = r_rd;
      end
      ST_DONE: begin
        read_data_out  = r_load_buf;
        result_alu_out = r_alu;
        rd_out         = r_rd;
        regwrite_out   = r_regwrite & ~r_killed;
        memtoreg_out   = r_memtoreg & ~r_killed;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized accesses against a byte-lane model.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] result_alu_in, write_data_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        memread_in, memwrite_in, memtoreg_in, regwrite_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic [63:0] read_data_out, result_alu_out;
  logic [4:0]  rd_out;
  logic        memtoreg_out, regwrite_out, stall, mem_fault;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .result_alu_in  (result_alu_in),
    .write_data_in  (write_data_in),
    .rd_in          (rd_in),
    .funct3_in      (funct3_in),
    .memread_in     (memread_in),
    .memwrite_in    (memwrite_in),
    .memtoreg_in    (memtoreg_in),
    .regwrite_in    (regwrite_in),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .read_data_out  (read_data_out),
    .result_alu_out (result_alu_out),
    .rd_out         (rd_out),
    .memtoreg_out   (memtoreg_out),
    .regwrite_out   (regwrite_out),
    .stall          (stall),
    .mem_fault      (mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input logic mr, input logic mw, input logic [2:0] f3,
                                     input logic [63:0] addr);
    int n;
    bit st;
    if (!(mr || mw)) return 1'b0;
    st = mw && !mr;
    n  = 1 << f3[1:0];
    return (f3 == 3'd7) || (st && f3 >= 3'd4) || ((int'(addr[2:0]) % n) != 0);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdat, input int off,
                                             input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdat[8*(off+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input int off, input logic [2:0] f3);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < (1 << f3[1:0]); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input int off);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8 - off; j++) w[8*(off+j) +: 8] = wd[8*j +: 8];
    return w;
  endfunction

  task automatic nop_inputs();
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
  endtask

  // Non-memory instruction: outputs must follow inputs in the same cycle
  task automatic alu_op(input logic [63:0] res, input logic [4:0] rd, input logic rw,
                        input logic mtr);
    nop_inputs();
    result_alu_in = res;
    rd_in         = rd;
    regwrite_in   = rw;
    memtoreg_in   = mtr;
    funct3_in     = 3'($urandom);
    @(negedge clk);
    chk("alu_result", result_alu_out, res);
    chk("alu_rd", 64'(rd_out), 64'(rd));
    chk("alu_regwrite", 64'(regwrite_out), 64'(rw));
    chk("alu_memtoreg", 64'(memtoreg_out), 64'(mtr));
    chk("alu_stall", 64'(stall), 64'd0);
    chk("alu_rdata", read_data_out, 64'd0);
    @(posedge clk); #1;
  endtask

  // delay = index of the WAIT cycle that sees the ack; negative means never ack
  task automatic access(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rdat,
                        input int delay, input logic [4:0] rd, input logic rw, input logic mtr);
    bit   fault, timed_out, st;
    int   off, nstall, nfault, fault_at;
    fault = model_fault(mr, mw, f3, addr);
    st    = mw && !mr;
    off   = int'(addr[2:0]);
    memread_in = mr; memwrite_in = mw; funct3_in = f3; result_alu_in = addr;
    write_data_in = wd; rd_in = rd; regwrite_in = rw; memtoreg_in = mtr;
    @(negedge clk);
    if (fault) begin
      chk("fault_pulse", 64'(mem_fault), 64'd1);
      chk("fault_stall", 64'(stall), 64'd0);
      chk("fault_regwrite", 64'(regwrite_out), 64'd0);
      chk("fault_memtoreg", 64'(memtoreg_out), 64'd0);
      @(posedge clk); #1;
      chk("fault_noreq", 64'(dmem_req), 64'd0);
      nop_inputs();
      return;
    end
    chk("detect_stall", 64'(stall), 64'd1);
    chk("detect_regwrite", 64'(regwrite_out), 64'd0);
    chk("detect_fault", 64'(mem_fault), 64'd0);
    chk("detect_noreq", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    chk("req_rise", 64'(dmem_req), 64'd1);
    chk("req_we", 64'(dmem_we), 64'(st));
    chk("req_addr", dmem_addr, {addr[63:3], 3'b000});
    if (st) begin
      chk("req_wstrb", 64'(dmem_wstrb), 64'(model_strb(off, f3)));
      chk("req_wdata", dmem_wdata, model_wdata(wd, off));
    end
    nstall = 1; nfault = 0; fault_at = -1; timed_out = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (c == delay) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdat;
      end
      @(negedge clk);
      if (stall) nstall++;
      if (mem_fault) begin
        nfault++;
        fault_at = c;
      end
      chk("wait_req_held", 64'(dmem_req), 64'd1);
      chk("wait_regwrite", 64'(regwrite_out), 64'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = {$urandom, $urandom};
      if (c == delay) break;
      if (delay < 0 && c == TMO - 1) begin
        timed_out = 1'b1;
        break;
      end
    end
    @(negedge clk);
    chk("done_stall", 64'(stall), 64'd0);
    chk("done_req_low", 64'(dmem_req), 64'd0);
    chk("done_fault", 64'(mem_fault), 64'd0);
    chk("stall_cycles", 64'(nstall), timed_out ? 64'(TMO + 1) : 64'(delay + 2));
    chk("fault_count", 64'(nfault), timed_out ? 64'd1 : 64'd0);
    if (timed_out) chk("fault_cycle", 64'(fault_at), 64'(TMO - 1));
    chk("done_regwrite", 64'(regwrite_out), timed_out ? 64'd0 : 64'(rw));
    chk("done_memtoreg", 64'(memtoreg_out), timed_out ? 64'd0 : 64'(mtr));
    chk("done_rd", 64'(rd_out), 64'(rd));
    chk("done_alu", result_alu_out, addr);
    if (mr && !timed_out) chk("done_rdata", read_data_out, model_load(rdat, off, f3));
    @(posedge clk); #1;
    nop_inputs();
  endtask

  initial begin
    reset = 1'b1;
    result_alu_in = '0; write_data_in = '0; rd_in = '0; funct3_in = '0;
    memread_in = 1'b0; memwrite_in = 1'b0; memtoreg_in = 1'b0; regwrite_in = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_we", 64'(dmem_we), 64'd0);
    chk("rst_addr", dmem_addr, 64'd0);
    chk("rst_wdata", dmem_wdata, 64'd0);
    chk("rst_wstrb", 64'(dmem_wstrb), 64'd0);
    chk("rst_fault", 64'(mem_fault), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    alu_op(64'h1234, 5'd5, 1'b1, 1'b0);
    // lb / lbu / lwu / sh / misaligned lw / timeout
    access(1, 0, 3'b000, 64'h1003, 64'd0, 64'h00000000_80000000, 0, 5'd7, 1, 1);
    access(1, 0, 3'b100, 64'h1003, 64'd0, 64'h00000000_80000000, 0, 5'd8, 1, 1);
    access(1, 0, 3'b110, 64'h1004, 64'd0, 64'h87654321_00000000, 1, 5'd9, 1, 1);
    access(0, 1, 3'b001, 64'h2006, 64'hBEEF, 64'd0, 0, 5'd0, 0, 0);
    access(1, 0, 3'b010, 64'h1002, 64'd0, 64'd0, 0, 5'd3, 1, 1);
    access(1, 0, 3'b011, 64'h3000, 64'd0, 64'd0, -1, 5'd4, 1, 1);
    // ack on the last permitted WAIT cycle must win over the timeout
    access(1, 0, 3'b011, 64'h3008, 64'd0, 64'hDEADBEEF_CAFEF00D, TMO - 1, 5'd6, 1, 1);
    access(0, 1, 3'b100, 64'h4000, 64'h55, 64'd0, 0, 5'd0, 0, 0);
    access(1, 0, 3'b111, 64'h4000, 64'd0, 64'd0, 0, 5'd1, 1, 1);
    alu_op(64'hFFFF_0000_1111_2222, 5'd31, 1'b1, 1'b1);

    // Reset in the middle of an outstanding load, then a stray ack
    memread_in = 1'b1; funct3_in = 3'b010; result_alu_in = 64'h5000; rd_in = 5'd2;
    regwrite_in = 1'b1; memtoreg_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", 64'(dmem_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", 64'(dmem_req), 64'd0);
    chk("midrst_fault", 64'(mem_fault), 64'd0);
    nop_inputs();
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_pass_rw", 64'(regwrite_out), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("stray_stall", 64'(stall), 64'd0);
    chk("stray_req", 64'(dmem_req), 64'd0);
    chk("stray_rdata", read_data_out, 64'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray_after_req", 64'(dmem_req), 64'd0);
    chk("stray_after_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    access(1, 0, 3'b001, 64'h6002, 64'd0, 64'h0000_0000_9ABC_0000, 0, 5'd11, 1, 1);

    for (int t = 0; t < 40; t++) begin
      logic        mr, mw;
      logic [2:0]  f3;
      logic [63:0] addr;
      int          r, dly;
      mr   = 1'($urandom);
      mw   = mr ? 1'($urandom) : 1'b1;
      f3   = 3'($urandom);
      addr = {$urandom, $urandom};
      if ($urandom_range(3) != 0) addr[2:0] = addr[2:0] & ~3'((1 << f3[1:0]) - 1);
      r    = int'($urandom_range(9));
      dly  = (r == 9) ? -1 : r % TMO;
      access(mr, mw, f3, addr, {$urandom, $urandom}, {$urandom, $urandom}, dly,
             5'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(1) != 0)
        alu_op({$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
